// File: rtl/vx_ti_tag_tracker.sv
// Tag tracker between the SFU TI execute stream and ti_bus: allocates tags, parks commit
// metadata per tag, and replays it with the out-of-order response. Optional perf counters: TI_TRACKER_PERF_EN.
module vx_ti_tag_tracker #(
  parameter int NUM_LANES = 4,
  parameter int NUM_TAGS  = 8,
  parameter int XLEN      = 32,
  parameter int UUID_W    = 44,
  parameter int NW_W      = 2,
  parameter int PC_BITS   = 30,
  parameter int NR_BITS   = 6,
  parameter int PID_W     = 1,
  localparam int TAG_W    = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1,
  localparam int META_W   = UUID_W + NW_W + NUM_LANES + PC_BITS + NR_BITS + 1 + PID_W + 1 + 1,
  localparam int DATA_W   = NUM_LANES * XLEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  exe_valid,
  output logic                  exe_ready,
  input  logic [META_W-1:0]     exe_meta,
  input  logic [DATA_W-1:0]     exe_data,
  output logic                  req_valid,
  input  logic                  req_ready,
  output logic [NUM_LANES-1:0]  req_mask,
  output logic [DATA_W-1:0]     req_data,
  output logic [TAG_W-1:0]      req_tag,
  input  logic                  rsp_valid,
  output logic                  rsp_ready,
  input  logic [TAG_W-1:0]      rsp_tag,
  input  logic [DATA_W-1:0]     rsp_data,
  output logic                  cm_valid,
  input  logic                  cm_ready,
  output logic [META_W-1:0]     cm_meta,
  output logic [DATA_W-1:0]     cm_data,
  output logic                  busy
`ifdef TI_TRACKER_PERF_EN
  ,
  output logic [31:0]           perf_full_stalls,
  output logic [TAG_W:0]        perf_max_inflight
`endif
);

  // Metadata layout from LSB: eop, sop, pid, wb, rd, PC, tmask, wid, uuid.
  localparam int TMASK_LSB = PC_BITS + NR_BITS + 1 + PID_W + 1 + 1;

  logic [NUM_TAGS-1:0] free_mask;
  logic [NUM_TAGS-1:0] free_next;
  logic [TAG_W:0]      count;
  logic [TAG_W:0]      count_next;
  logic [TAG_W-1:0]    alloc_tag;
  logic                has_free;
  logic                exe_fire;
  logic                rsp_fire;
  logic [META_W-1:0]   meta_ram [NUM_TAGS];

  assign has_free  = |free_mask;
  assign req_valid = exe_valid && has_free;
  assign exe_ready = has_free && req_ready;
  assign exe_fire  = exe_valid && exe_ready;
  assign req_mask  = exe_meta[TMASK_LSB +: NUM_LANES];
  assign req_data  = exe_data;
  assign req_tag   = alloc_tag;

  assign rsp_ready = !cm_valid || cm_ready;
  // A response naming a free tag is illegal; it is swallowed without touching state.
  assign rsp_fire  = rsp_valid && rsp_ready && !free_mask[rsp_tag];

  assign busy = (count != '0) || cm_valid;

  always_comb begin
    alloc_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (free_mask[i]) alloc_tag = TAG_W'(i);
    end
  end

  for (genvar gi = 0; gi < NUM_TAGS; gi++) begin : g_free
    assign free_next[gi] = (rsp_fire && (rsp_tag == TAG_W'(gi))) ? 1'b1 :
                           (exe_fire && (alloc_tag == TAG_W'(gi))) ? 1'b0 :
                           free_mask[gi];
  end

  always_comb begin
    count_next = count;
    case ({exe_fire, rsp_fire})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      free_mask <= '1;
      count     <= '0;
    end else begin
      free_mask <= free_next;
      count     <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (exe_fire) meta_ram[alloc_tag] <= exe_meta;
  end

  // Commit register: the table read is registered here, giving one cycle response-to-commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cm_valid <= 1'b0;
      cm_meta  <= '0;
      cm_data  <= '0;
    end else if (rsp_fire) begin
      cm_valid <= 1'b1;
      cm_meta  <= meta_ram[rsp_tag];
      cm_data  <= rsp_data;
    end else if (cm_ready) begin
      cm_valid <= 1'b0;
    end
  end

`ifdef TI_TRACKER_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_full_stalls  <= '0;
      perf_max_inflight <= '0;
    end else begin
      if (exe_valid && !has_free && (perf_full_stalls != '1))
        perf_full_stalls <= perf_full_stalls + 32'd1;
      if (count_next > perf_max_inflight)
        perf_max_inflight <= count_next;
    end
  end
`endif

`ifndef SYNTHESIS
  ti_rsp_on_live_tag: assert property (@(posedge clk) disable iff (reset)
    (rsp_valid && rsp_ready) |-> !free_mask[rsp_tag]);
  ti_count_matches_mask: assert property (@(posedge clk) disable iff (reset)
    count == ((TAG_W+1)'(NUM_TAGS) - (TAG_W+1)'($countones(free_mask))));
`endif

endmodule
